// File: rtl/pll_reset_supervisor_pkg.sv
// Shared clocking definitions for the PLL reset/lock supervisor and its reset bridges.
// Holds the supervisor state encoding, default timing constants and counter sizing.
package pll_reset_supervisor_pkg;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } pll_sup_state_t;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 1000000;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_SYNC_STAGES    = 2;

   localparam int             RELOCK_W   = 8;
   localparam logic [RELOCK_W-1:0] RELOCK_MAX = 8'hFF;

   // One bit of headroom above the largest count keeps the shared counter from aliasing.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/pll_reset_supervisor_if.sv
// Board-clocking handshake between the supervisor and the PLL / system reset consumers.
// The master side is the supervisor itself.
interface pll_reset_supervisor_if;
   import pll_reset_supervisor_pkg::*;

   logic                locked;
   logic                pll_rst;
   logic                sys_rst;
   logic                ready;
   logic                timeout_flag;
   logic [RELOCK_W-1:0] relock_count;

   modport master (
      input  locked,
      output pll_rst, sys_rst, ready, timeout_flag, relock_count
   );

   modport slave (
      output locked,
      input  pll_rst, sys_rst, ready, timeout_flag, relock_count
   );

endinterface

// File: rtl/pll_reset_supervisor_sync_bit.sv
// sync_bit: N-stage single-bit synchronizer with synchronous clear.
// Shared with the per-domain reset bridges; fewer than two stages is raised to two.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);
   localparam int N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] sync_r;

   // Shift chain; clearing forces the output low until fresh samples propagate.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[N-2:0], d};
      end
   end

   assign q = sync_r[N-1];

endmodule

// File: rtl/pll_reset_supervisor.sv
// PLL reset/lock supervisor: sequences PLL reset, waits for a stable lock, then releases
// the system reset. Outputs are registered one cycle behind the state register.
module pll_reset_supervisor
   import pll_reset_supervisor_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic                   refclk,
   input  logic                   rst,
   pll_reset_supervisor_if.master sup
);
   localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

   pll_sup_state_t      state_r;
   pll_sup_state_t      state_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;
   logic                locked_s;
   logic                timeout_evt_s;
   logic                relock_evt_s;
   logic                timeout_evt_r;
   logic                relock_evt_r;

   logic                pll_rst_r;
   logic                sys_rst_r;
   logic                ready_r;
   logic                timeout_flag_r;
   logic [RELOCK_W-1:0] relock_count_r;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk (refclk),
      .clr (rst),
      .d   (sup.locked),
      .q   (locked_s)
   );

   // Next-state logic; the shared counter restarts on every state change.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r + CNT_ONE;
      timeout_evt_s = 1'b0;
      relock_evt_s  = 1'b0;
      case (state_r)
         PLL_RESET: begin
            if (cnt_r == RST_LAST) begin
               state_nxt_s = WAIT_LOCK;
            end else begin
               state_nxt_s = PLL_RESET;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt_s = STABILIZE;
            end else if (cnt_r == TMO_LAST) begin
               state_nxt_s   = PLL_RESET;
               timeout_evt_s = 1'b1;
            end else begin
               state_nxt_s = WAIT_LOCK;
            end
         end
         STABILIZE: begin
            if (!locked_s) begin
               state_nxt_s = WAIT_LOCK;
            end else if (cnt_r == STB_LAST) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = STABILIZE;
            end
         end
         RUN: begin
            // Lock loss leaves the PLL alone; it relocks by itself or the timeout catches it.
            if (!locked_s) begin
               state_nxt_s  = WAIT_LOCK;
               relock_evt_s = 1'b1;
            end else begin
               state_nxt_s = RUN;
            end
         end
         default: begin
            state_nxt_s = PLL_RESET;
         end
      endcase
      if (state_nxt_s != state_r) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // State, counter and one-cycle event pulses feeding the output stage.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_r       <= PLL_RESET;
         cnt_r         <= '0;
         timeout_evt_r <= 1'b0;
         relock_evt_r  <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         cnt_r         <= cnt_nxt_s;
         timeout_evt_r <= timeout_evt_s;
         relock_evt_r  <= relock_evt_s;
      end
   end

   // Registered outputs derived from the settled state and the event pulses.
   always_ff @(posedge refclk) begin
      if (rst) begin
         pll_rst_r      <= 1'b1;
         sys_rst_r      <= 1'b1;
         ready_r        <= 1'b0;
         timeout_flag_r <= 1'b0;
         relock_count_r <= '0;
      end else begin
         pll_rst_r      <= (state_r == PLL_RESET);
         sys_rst_r      <= (state_r != RUN);
         ready_r        <= (state_r == RUN);
         timeout_flag_r <= timeout_flag_r | timeout_evt_r;
         if (relock_evt_r && (relock_count_r != RELOCK_MAX)) begin
            relock_count_r <= relock_count_r + 8'd1;
         end else begin
            relock_count_r <= relock_count_r;
         end
      end
   end

   assign sup.pll_rst      = pll_rst_r;
   assign sup.sys_rst      = sys_rst_r;
   assign sup.ready        = ready_r;
   assign sup.timeout_flag = timeout_flag_r;
   assign sup.relock_count = relock_count_r;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Self-checking bench for pll_reset_supervisor: directed scenarios plus random lock
// activity, compared every cycle against a deadline-based reference model.
module tb_pll_reset_supervisor;
   import pll_reset_supervisor_pkg::*;

   localparam int P_RST  = 4;
   localparam int P_TMO  = 20;
   localparam int P_STB  = 8;
   localparam int P_SYNC = 2;

   localparam int M_RESET = 0;
   localparam int M_WAIT  = 1;
   localparam int M_STAB  = 2;
   localparam int M_RUN   = 3;

   logic refclk = 1'b0;
   logic rst    = 1'b1;

   pll_reset_supervisor_if bus_if ();

   pll_reset_supervisor #(
      .PLL_RST_CYCLES (P_RST),
      .LOCK_TIMEOUT   (P_TMO),
      .STABLE_CYCLES  (P_STB),
      .SYNC_STAGES    (P_SYNC)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .sup    (bus_if)
   );

   always #5 refclk = ~refclk;

   int checks = 0;
   int errors = 0;

   // Reference model: phase plus the edge at which it was entered; transitions fire on deadlines.
   int mode;
   int enter_cyc;
   int cyc = 0;
   int rel_cyc = -1;
   bit sq[$];
   bit pend_tmo, pend_rel;
   int exp_pll, exp_sys, exp_rdy, exp_tmo, exp_cnt;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, rel_cyc);
      end
   endtask

   task automatic model_edge(input bit lk, input bit r);
      bit ls;
      if (r) begin
         mode = M_RESET;
         enter_cyc = cyc;
         sq = {};
         for (int i = 0; i < P_SYNC; i++) sq.push_back(1'b0);
         exp_pll = 1; exp_sys = 1; exp_rdy = 0; exp_tmo = 0; exp_cnt = 0;
         pend_tmo = 1'b0; pend_rel = 1'b0;
      end else begin
         ls = sq.pop_front();
         sq.push_back(lk);
         exp_pll = (mode == M_RESET) ? 1 : 0;
         exp_sys = (mode != M_RUN) ? 1 : 0;
         exp_rdy = (mode == M_RUN) ? 1 : 0;
         if (pend_tmo) exp_tmo = 1;
         if (pend_rel && exp_cnt < 255) exp_cnt++;
         pend_tmo = 1'b0;
         pend_rel = 1'b0;
         case (mode)
            M_RESET: if (cyc == enter_cyc + P_RST) begin mode = M_WAIT; enter_cyc = cyc; end
            M_WAIT: begin
               if (ls) begin mode = M_STAB; enter_cyc = cyc; end
               else if (cyc == enter_cyc + P_TMO) begin mode = M_RESET; enter_cyc = cyc; pend_tmo = 1'b1; end
            end
            M_STAB: begin
               if (!ls) begin mode = M_WAIT; enter_cyc = cyc; end
               else if (cyc == enter_cyc + P_STB) begin mode = M_RUN; enter_cyc = cyc; end
            end
            default: if (!ls) begin mode = M_WAIT; enter_cyc = cyc; pend_rel = 1'b1; end
         endcase
      end
      cyc++;
   endtask

   // One clock: drive at negedge, model at posedge, compare at the next negedge.
   task automatic step(input bit lk, input bit r);
      bus_if.locked = lk;
      rst = r;
      @(posedge refclk);
      model_edge(lk, r);
      @(negedge refclk);
      rel_cyc = r ? -1 : rel_cyc + 1;
      check_eq("pll_rst", int'(bus_if.pll_rst), exp_pll);
      check_eq("sys_rst", int'(bus_if.sys_rst), exp_sys);
      check_eq("ready", int'(bus_if.ready), exp_rdy);
      check_eq("timeout_flag", int'(bus_if.timeout_flag), exp_tmo);
      check_eq("relock_count", int'(bus_if.relock_count), exp_cnt);
   endtask

   initial begin
      bit cur;
      int flip_div;
      bus_if.locked = 1'b0;

      // Reset, then normal lock at cycle 10.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      for (int c = 0; c < 30; c++) begin
         step(c >= 10, 1'b0);
         if (c == 3)  check_eq("norm_pll_rst_c3", int'(bus_if.pll_rst), 1);
         if (c == 4)  check_eq("norm_pll_rst_c4", int'(bus_if.pll_rst), 0);
         if (c == 20) check_eq("norm_sys_rst_c20", int'(bus_if.sys_rst), 1);
         if (c == 21) check_eq("norm_ready_c21", int'(bus_if.ready), 1);
      end

      // Lock loss in RUN for one cycle, then relock.
      for (int d = 0; d < 16; d++) begin
         step(d != 0, 1'b0);
         check_eq("loss_pll_rst", int'(bus_if.pll_rst), 0);
         if (d == 2)  check_eq("loss_sys_rst_d2", int'(bus_if.sys_rst), 0);
         if (d == 3)  check_eq("loss_sys_rst_d3", int'(bus_if.sys_rst), 1);
         if (d == 3)  check_eq("loss_relock_d3", int'(bus_if.relock_count), 1);
         if (d == 11) check_eq("relock_sys_rst_d11", int'(bus_if.sys_rst), 1);
         if (d == 12) check_eq("relock_sys_rst_d12", int'(bus_if.sys_rst), 0);
      end

      // Saturation over 300 loss/relock cycles.
      for (int n = 0; n < 300; n++) begin
         for (int d = 0; d < 14; d++) step(d != 0, 1'b0);
      end
      check_eq("sat_relock", int'(bus_if.relock_count), 255);

      // Lock never arrives: restart every 24 cycles.
      step(1'b0, 1'b1);
      for (int c = 0; c < 60; c++) begin
         step(1'b0, 1'b0);
         if (c == 23) check_eq("tmo_flag_c23", int'(bus_if.timeout_flag), 0);
         if (c == 24) check_eq("tmo_flag_c24", int'(bus_if.timeout_flag), 1);
         if (c == 28) check_eq("tmo_pll_rst_c28", int'(bus_if.pll_rst), 0);
         if (c == 48) check_eq("tmo_pll_rst_c48", int'(bus_if.pll_rst), 1);
      end

      // Reach RUN with three lock losses, then reset mid-RUN.
      for (int c = 0; c < 20; c++) step(1'b1, 1'b0);
      for (int n = 0; n < 3; n++) begin
         for (int d = 0; d < 14; d++) step(d != 0, 1'b0);
      end
      check_eq("pre_rst_relock", int'(bus_if.relock_count), 3);
      check_eq("pre_rst_tmo", int'(bus_if.timeout_flag), 1);
      check_eq("pre_rst_ready", int'(bus_if.ready), 1);
      step(1'b1, 1'b1);
      check_eq("mid_rst_pll_rst", int'(bus_if.pll_rst), 1);
      check_eq("mid_rst_sys_rst", int'(bus_if.sys_rst), 1);
      check_eq("mid_rst_relock", int'(bus_if.relock_count), 0);
      check_eq("mid_rst_tmo", int'(bus_if.timeout_flag), 0);

      // Glitch while the stability count is at 5.
      step(1'b0, 1'b1);
      for (int c = 0; c < 30; c++) begin
         step((c >= 5) && (c != 11), 1'b0);
         if (c == 22) check_eq("glitch_sys_rst_c22", int'(bus_if.sys_rst), 1);
         if (c == 23) check_eq("glitch_sys_rst_c23", int'(bus_if.sys_rst), 0);
      end

      // Random lock activity with occasional resets.
      cur = 1'b0;
      flip_div = 30;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) flip_div = ($urandom_range(0, 1) == 0) ? 3 : 40;
         if ($urandom_range(0, flip_div - 1) == 0) cur = ~cur;
         step(cur, $urandom_range(0, 499) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
